instr_fetch_unit: RTL and testbench

- Front end of the gpu core, directly downstream of the shader program memory. The memory returns data_input one clock after input_addr.
- Issues a sequential 20-bit fetch address stream and captures returned 16-bit instructions with their PCs into a small FIFO.
- Presents instructions to the decoder over a valid/ready handshake.
- Handles decoder-driven redirects (branch/jump) and halt.

---
 rtl/gpu_fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_fetch_pkg.sv
// Shared types and widths for the shader instruction fetch front end.
package gpu_fetch_pkg;

  localparam int ADDR_W = 20;
  localparam int INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = '0;

  // One prefetched instruction together with the address it was read from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer for the instruction fetch unit: synchronous FIFO of
// fetch_entry_t. Flush has priority over push and pop. The caller must not
// push into a full FIFO unless it pops in the same cycle.
module fetch_fifo
  import gpu_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output fetch_entry_t       head_entry,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  fetch_entry_t   mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] rd_ptr_q;
  logic           do_pop;

  assign do_pop     = pop & ~empty;
  assign count      = wr_ptr_q - rd_ptr_q;
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (count == CNT_W'(DEPTH));
  assign head_entry = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Entry storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
    end
  end

  // Read/write pointers with an extra wrap bit so full and empty differ.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues a sequential fetch address stream to the
// shader program memory (one-cycle read latency), captures returned words with
// their PCs in a prefetch FIFO and hands them to the decoder over valid/ready.
// Decoder redirects flush everything and restart fetch; halt stops issue.
// Optional build macro FETCH_BYPASS_EN: when the FIFO is empty, the word
// returning from memory is presented to the decoder directly in the same cycle.
module instr_fetch_unit
  import gpu_fetch_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               KEY0,
  output logic [ADDR_W-1:0]  input_addr,
  input  logic [INSTR_W-1:0] data_input,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               fetch_idle
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;
  logic              fetch_idle_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  fetch_entry_t      head_entry;
  fetch_entry_t      push_entry;

  logic [CNT_W:0]    credit_used;
  logic              issue;
  logic              bypass_hit;
  logic              bypass_take;

  // Slots already committed: buffered entries plus the word on its way back.
  // A pop in the same cycle deliberately does not free a slot for issue.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign issue       = KEY0 & ~halt & ~redirect_valid &
                       (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = fifo_empty & inflight_q;
`else
  assign bypass_hit = 1'b0;
`endif

  // During a redirect the decoder's accept is ignored; the flush wins.
  assign bypass_take = bypass_hit & instr_ready & ~redirect_valid;
  assign fifo_pop    = ~fifo_empty & instr_ready & ~redirect_valid;
  assign fifo_push   = inflight_q & ~bypass_take & (~fifo_full | fifo_pop);
  assign push_entry  = '{pc: inflight_pc_q, instr: data_input};

  assign input_addr  = pc_q;
  assign fetch_idle  = fetch_idle_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (KEY0),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head_entry (head_entry),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Decoder-facing head: FIFO head first, bypassed memory word otherwise, zero when idle.
  always_comb begin
    instr_valid = 1'b0;
    instr_data  = '0;
    instr_pc    = '0;
    if (!fifo_empty) begin
      instr_valid = 1'b1;
      instr_data  = head_entry.instr;
      instr_pc    = head_entry.pc;
    end else if (bypass_hit) begin
      instr_valid = 1'b1;
      instr_data  = data_input;
      instr_pc    = inflight_pc_q;
    end
  end

  // Fetch PC, in-flight tracking and idle flag; redirect overrides issue.
  always_ff @(posedge clk) begin
    if (!KEY0) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fetch_idle_q  <= halt;
    end else begin
      fetch_idle_q <= halt & (fifo_count == '0) & ~inflight_q;
      if (redirect_valid) begin
        pc_q       <= redirect_pc;
        inflight_q <= 1'b0;
      end else if (issue) begin
        pc_q          <= pc_q + ADDR_W'(1);
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
      end else begin
        inflight_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. The program memory is a
// synchronous-read model whose contents are a fixed function of the address.
// The reference model is the architectural instruction stream: after reset or
// a redirect the decoder must see consecutive PCs with matching memory words.
module tb_instr_fetch_unit;
  import gpu_fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic               clk = 1'b0;
  logic               KEY0 = 1'b0;
  logic [ADDR_W-1:0]  input_addr;
  logic [INSTR_W-1:0] data_input = '0;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic               halt = 1'b0;
  logic               fetch_idle;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .KEY0           (KEY0),
    .input_addr     (input_addr),
    .data_input     (data_input),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_idle     (fetch_idle)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (16'h1000 + a[15:0]) ^ {a[19:16], 12'h000};
  endfunction

  always @(posedge clk) data_input <= mem_word(input_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    KEY0 = 1'b0;
    instr_ready = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    checks++; if (instr_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", instr_data); end
    checks++; if (instr_pc !== 20'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000", instr_pc); end
    checks++; if (input_addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000", input_addr); end
    checks++; if (fetch_idle !== 1'b0) begin errors++; $display("FAIL reset_idle_nohalt: got %0b want 0", fetch_idle); end
    halt = 1'b1;
    tick();
    checks++; if (fetch_idle !== 1'b1) begin errors++; $display("FAIL reset_idle_halt: got %0b want 1", fetch_idle); end
    halt = 1'b0;
    tick();
  endtask

  task automatic test_sequential();
    int first;
    do_reset();
    instr_ready = 1'b1;
    KEY0 = 1'b1;
    first = -1;
    for (int c = 1; c <= 10 && first < 0; c++) begin
      tick();
      if (instr_valid === 1'b1) first = c;
    end
    checks++; if (first != 2 - BYP) begin errors++; $display("FAIL seq_latency: got %0d want %0d", first, 2 - BYP); end
    if (first > 0) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 20'(i) || instr_data !== mem_word(20'(i))) begin
          errors++;
          $display("FAIL seq_item%0d: got v=%0b pc=%h d=%h want v=1 pc=%h d=%h",
                   i, instr_valid, instr_pc, instr_data, 20'(i), mem_word(20'(i)));
        end
        tick();
      end
    end
  endtask

  task automatic test_backpressure();
    int unstable;
    int n;
    int gaps;
    do_reset();
    KEY0 = 1'b1;
    unstable = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (instr_valid === 1'b1 && (instr_pc !== 20'h0 || instr_data !== mem_word(20'h0))) unstable++;
    end
    checks++; if (input_addr !== 20'h4) begin errors++; $display("FAIL bp_pc_frozen: got %h want 00004", input_addr); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_head_stable: got %0d changed cycles want 0", unstable); end
    instr_ready = 1'b1;
    n = 0;
    gaps = 0;
    for (int c = 0; c < 40 && n < 12; c++) begin
      if (instr_valid === 1'b1) begin
        checks++;
        if (instr_pc !== 20'(n) || instr_data !== mem_word(20'(n))) begin
          errors++;
          $display("FAIL bp_item%0d: got pc=%h d=%h want pc=%h d=%h", n, instr_pc, instr_data, 20'(n), mem_word(20'(n)));
        end
        n++;
      end else begin
        gaps++;
      end
      tick();
    end
    checks++; if (n != 12) begin errors++; $display("FAIL bp_count: got %0d want 12", n); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL bp_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_redirect();
    int first;
    int c;
    logic [ADDR_W-1:0]  got_pc;
    logic [INSTR_W-1:0] got_data;
    do_reset();
    KEY0 = 1'b1;
    repeat (4) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 20'h0) begin errors++; $display("FAIL rd_pre: got v=%0b pc=%h want v=1 pc=00000", instr_valid, instr_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 20'h00120;
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    first = -1;
    got_pc = '0;
    got_data = '0;
    c = 1;
    while (c <= 10 && first < 0) begin
      if (instr_valid === 1'b1) begin
        first = c;
        got_pc = instr_pc;
        got_data = instr_data;
      end else begin
        tick();
        c++;
      end
    end
    checks++; if (first != 3 - BYP) begin errors++; $display("FAIL rd_latency: got %0d want %0d", first, 3 - BYP); end
    checks++; if (got_pc !== 20'h00120 || got_data !== mem_word(20'h00120)) begin errors++; $display("FAIL rd_first: got pc=%h d=%h want pc=00120 d=%h", got_pc, got_data, mem_word(20'h00120)); end
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 20'h00120 + 20'(i) || instr_data !== mem_word(20'h00120 + 20'(i))) begin
        errors++;
        $display("FAIL rd_next%0d: got v=%0b pc=%h want pc=%h", i, instr_valid, instr_pc, 20'h00120 + 20'(i));
      end
    end
  endtask

  task automatic test_halt();
    int n;
    int bad;
    int first;
    do_reset();
    instr_ready = 1'b1;
    KEY0 = 1'b1;
    n = 0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (instr_valid === 1'b1) begin
        if (instr_pc !== 20'(n) || instr_data !== mem_word(20'(n))) bad++;
        n++;
      end
      if (input_addr === 20'h5) break;
    end
    halt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (instr_valid === 1'b1) begin
        if (instr_pc !== 20'(n) || instr_data !== mem_word(20'(n))) bad++;
        n++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL halt_stream: got %0d bad items want 0", bad); end
    checks++; if (n != 5) begin errors++; $display("FAIL halt_drained: got %0d items want 5", n); end
    checks++; if (fetch_idle !== 1'b1) begin errors++; $display("FAIL halt_idle: got %0b want 1", fetch_idle); end
    checks++; if (input_addr !== 20'h5) begin errors++; $display("FAIL halt_pc: got %h want 00005", input_addr); end
    checks++; if (instr_valid !== 1'b0 || instr_data !== 16'h0 || instr_pc !== 20'h0) begin errors++; $display("FAIL halt_outputs_zero: got v=%0b d=%h pc=%h want 0", instr_valid, instr_data, instr_pc); end
    halt = 1'b0;
    first = -1;
    for (int c = 0; c < 10 && first < 0; c++) begin
      tick();
      if (instr_valid === 1'b1) first = c;
    end
    checks++; if (first < 0 || instr_pc !== 20'h5 || instr_data !== mem_word(20'h5)) begin errors++; $display("FAIL halt_resume: got pc=%h d=%h want pc=00005 d=%h", instr_pc, instr_data, mem_word(20'h5)); end
    tick();
    checks++; if (fetch_idle !== 1'b0) begin errors++; $display("FAIL halt_idle_clear: got %0b want 0", fetch_idle); end
  endtask

  task automatic test_wrap();
    int n;
    logic [ADDR_W-1:0] e;
    do_reset();
    KEY0 = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 20'hFFFFE;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (instr_valid === 1'b1) begin
        e = 20'hFFFFE + 20'(n);
        checks++;
        if (instr_pc !== e || instr_data !== mem_word(e)) begin
          errors++;
          $display("FAIL wrap_item%0d: got pc=%h d=%h want pc=%h d=%h", n, instr_pc, instr_data, e, mem_word(e));
        end
        n++;
      end
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", n); end
  endtask

  task automatic test_reset_midop();
    int first;
    do_reset();
    KEY0 = 1'b1;
    repeat (8) tick();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got v=%0b want 1", instr_valid); end
    KEY0 = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b0 || instr_data !== 16'h0 || instr_pc !== 20'h0) begin errors++; $display("FAIL rst_mid_outputs: got v=%0b d=%h pc=%h want 0", instr_valid, instr_data, instr_pc); end
    checks++; if (input_addr !== 20'h0) begin errors++; $display("FAIL rst_mid_addr: got %h want 00000", input_addr); end
    KEY0 = 1'b1;
    instr_ready = 1'b1;
    first = -1;
    for (int c = 1; c <= 10 && first < 0; c++) begin
      tick();
      if (instr_valid === 1'b1) first = c;
    end
    checks++; if (first != 2 - BYP || instr_pc !== 20'h0 || instr_data !== mem_word(20'h0)) begin errors++; $display("FAIL rst_mid_restart: got lat=%0d pc=%h want lat=%0d pc=00000", first, instr_pc, 2 - BYP); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] prev_addr;
    logic [ADDR_W-1:0] prev_rpc;
    logic              prev_halt;
    logic              prev_redir;
    logic              ok;
    int                accepts;
    do_reset();
    KEY0 = 1'b1;
    exp_pc = '0;
    accepts = 0;
    prev_addr = input_addr;
    prev_rpc = '0;
    prev_halt = 1'b0;
    prev_redir = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        if (prev_redir) ok = (input_addr === prev_rpc);
        else if (prev_halt) ok = (input_addr === prev_addr);
        else ok = (input_addr === prev_addr) || (input_addr === prev_addr + 20'd1);
        checks++;
        if (!ok) begin errors++; $display("FAIL rnd_addr: cycle %0d got %h prev %h", c, input_addr, prev_addr); end
      end
      checks++;
      if (instr_valid !== 1'b1 && (instr_data !== 16'h0 || instr_pc !== 20'h0)) begin
        errors++;
        $display("FAIL rnd_idle_zero: cycle %0d got d=%h pc=%h want 0", c, instr_data, instr_pc);
      end
      instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      redirect_valid = !halt && ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 255)) : 20'($urandom);
      if (instr_valid === 1'b1 && instr_ready && !redirect_valid) begin
        checks++;
        if (instr_pc !== exp_pc || instr_data !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rnd_stream: cycle %0d got pc=%h d=%h want pc=%h d=%h", c, instr_pc, instr_data, exp_pc, mem_word(exp_pc));
        end
        exp_pc = instr_pc + 20'd1;
        accepts++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_addr = input_addr;
      prev_rpc = redirect_pc;
      prev_halt = halt;
      prev_redir = redirect_valid;
      tick();
    end
    redirect_valid = 1'b0;
    halt = 1'b0;
    checks++; if (accepts < 300) begin errors++; $display("FAIL rnd_progress: got %0d accepts want >= 300", accepts); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
